// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizes the SPI pins into clk_i, shifts
// MSB-first words and queues them in a first-word-fall-through FIFO.
module spi_slave_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  spi_sclk,
    input  logic                  spi_sdo,
    input  logic                  spi_cs,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic                  err_clr_i,
    output logic                  overflow_o,
    output logic                  frame_err_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    logic [1:0] sclk_sync_q, sclk_sync_d, sdo_sync_q, sdo_sync_d, cs_sync_q, cs_sync_d;
    logic       sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic [1:0] warm_q, warm_d;
    logic       armed_q, armed_d;
    logic       sclk_rise_q, sclk_rise_d, cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
    logic       sdo_q, sdo_d;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  push, ferr_evt;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  empty, full, pop, wr_en, ovf_evt;
    logic                  ovf_q, ovf_d, ferr_q, ferr_d;

    // Pin synchronizers plus one registered event stage. A falling cs is only
    // honoured once a real high level has been seen after reset, so a cs that
    // is already low at reset release cannot start a frame.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], spi_sclk};
        sdo_sync_d  = {sdo_sync_q[0], spi_sdo};
        cs_sync_d   = {cs_sync_q[0], spi_cs};
        sclk_prev_d = sclk_sync_q[1];
        cs_prev_d   = cs_sync_q[1];
        warm_d      = {warm_q[0], 1'b1};
        armed_d     = armed_q | (warm_q[1] & cs_sync_q[1]);
        sclk_rise_d = sclk_sync_q[1] & ~sclk_prev_q;
        cs_fall_d   = armed_q & ~cs_sync_q[1] & cs_prev_q;
        cs_rise_d   = cs_sync_q[1] & ~cs_prev_q;
        sdo_d       = sdo_sync_q[1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= 2'b00;
            sdo_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            warm_q      <= 2'b00;
            armed_q     <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdo_sync_q  <= sdo_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            sclk_rise_q <= sclk_rise_d;
            cs_fall_q   <= cs_fall_d;
            cs_rise_q   <= cs_rise_d;
            sdo_q       <= sdo_d;
        end
    end

    // The sclk edge is handled before cs rising, so a final bit arriving with
    // cs deassertion still completes its word.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise_q) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], sdo_q};
                    if (cnt_q == LAST_BIT) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (cs_rise_q) begin
                    state_d  = IDLE;
                    ferr_evt = (cnt_d != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO with one extra pointer bit; a pop frees the slot a same-cycle push needs.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = ~empty & rx_ready_i;
        wr_en    = push & (~full | pop);
        ovf_evt  = push & full & ~pop;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        ovf_d    = (ovf_q & ~err_clr_i) | ovf_evt;
        ferr_d   = (ferr_q & ~err_clr_i) | ferr_evt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shreg_d;
        end
    end

    assign rx_valid_o  = ~empty;
    assign rx_data_o   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives SPI frames bit by bit and checks the popped
// word stream and error flags against a word-level queue model.
module tb_spi_slave_rx;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int H = 4;

    logic          clk_i, rst_ni, spi_sclk, spi_sdo, spi_cs;
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o, rx_ready_i, err_clr_i, overflow_o, frame_err_o, busy_o;

    int            cmp_cnt = 0;
    int            err_cnt = 0;
    int            rdy_mode = 0;
    logic          pulse_req = 1'b0;
    logic [DW-1:0] got [$];
    int            valid_cycles = 0;

    spi_slave_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .spi_sclk(spi_sclk), .spi_sdo(spi_sdo),
        .spi_cs(spi_cs), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .err_clr_i(err_clr_i), .overflow_o(overflow_o),
        .frame_err_o(frame_err_o), .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Consumer: 0 = stalled, 1 = always ready, 2 = random; pulse_req forces one ready cycle.
    initial begin
        rx_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            rx_ready_i = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1) || pulse_req;
        end
    end

    // Record every accepted word.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && rx_valid_o) valid_cycles++;
            if (rst_ni && rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
        end
    end

    task automatic spi_bit(input logic b);
        spi_sdo = b;
        repeat (H) @(posedge clk_i); #1 spi_sclk = 1'b1;
        repeat (H) @(posedge clk_i); #1 spi_sclk = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) spi_bit(w[i]);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        repeat (2 * H) @(posedge clk_i); #1;
    endtask

    task automatic cs_high();
        repeat (H) @(posedge clk_i); #1 spi_cs = 1'b1;
        repeat (2 * H) @(posedge clk_i); #1;
    endtask

    task automatic clr_err();
        @(posedge clk_i); #1 err_clr_i = 1'b1;
        @(posedge clk_i); #1 err_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        cmp_cnt++; if (rx_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", rx_valid_o); end
        cmp_cnt++; if (rx_data_o !== '0) begin err_cnt++; $display("FAIL rst_data: got %h want 0", rx_data_o); end
        cmp_cnt++; if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf: got %b want 0", overflow_o); end
        cmp_cnt++; if (frame_err_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ferr: got %b want 0", frame_err_o); end
        cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (5) @(posedge clk_i); #1;
    endtask

    task automatic test_single();
        logic [DW-1:0] w = 32'hA5A50F0F;
        int base = got.size();
        rdy_mode = 1;
        cs_low();
        cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL single_busy: got %b want 1", busy_o); end
        for (int i = DW - 1; i >= 1; i--) spi_bit(w[i]);
        spi_sdo = w[0];
        repeat (H) @(posedge clk_i); #1 spi_sclk = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        cmp_cnt++; if (rx_valid_o !== 1'b0) begin err_cnt++; $display("FAIL single_lat_early: got %b want 0", rx_valid_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        cmp_cnt++; if (rx_valid_o !== 1'b1) begin err_cnt++; $display("FAIL single_lat: got %b want 1", rx_valid_o); end
        cmp_cnt++; if (rx_data_o !== w) begin err_cnt++; $display("FAIL single_head: got %h want %h", rx_data_o, w); end
        @(posedge clk_i); #1 spi_sclk = 1'b0;
        cs_high();
        cmp_cnt++; if (got.size() - base !== 1) begin err_cnt++; $display("FAIL single_count: got %0d want 1", got.size() - base); end
        if (got.size() > base) begin
            cmp_cnt++; if (got[base] !== w) begin err_cnt++; $display("FAIL single_data: got %h want %h", got[base], w); end
        end
        cmp_cnt++; if ({overflow_o, frame_err_o, busy_o} !== 3'b000) begin err_cnt++; $display("FAIL single_flags: got %b want 000", {overflow_o, frame_err_o, busy_o}); end
    endtask

    task automatic test_overflow();
        int base = got.size();
        rdy_mode = 0;
        cs_low();
        for (int k = 1; k <= 5; k++) send_word(DW'(k));
        cs_high();
        cmp_cnt++; if (overflow_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        cmp_cnt++; if (rx_data_o !== DW'(1)) begin err_cnt++; $display("FAIL ovf_head: got %h want 1", rx_data_o); end
        cmp_cnt++; if (frame_err_o !== 1'b0) begin err_cnt++; $display("FAIL ovf_ferr: got %b want 0", frame_err_o); end
        rdy_mode = 1;
        repeat (20) @(posedge clk_i); #1;
        cmp_cnt++; if (got.size() - base !== 4) begin err_cnt++; $display("FAIL ovf_count: got %0d want 4", got.size() - base); end
        for (int k = 0; k < 4 && base + k < got.size(); k++) begin
            cmp_cnt++; if (got[base+k] !== DW'(k + 1)) begin err_cnt++; $display("FAIL ovf_order%0d: got %h want %h", k, got[base+k], k + 1); end
        end
        clr_err();
        @(negedge clk_i);
        cmp_cnt++; if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL ovf_clr: got %b want 0", overflow_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_short_frame();
        int vbase = valid_cycles;
        rdy_mode = 1;
        cs_low();
        for (int i = 0; i < 7; i++) spi_bit(1'($urandom_range(0, 1)));
        cs_high();
        cmp_cnt++; if (frame_err_o !== 1'b1) begin err_cnt++; $display("FAIL short_ferr: got %b want 1", frame_err_o); end
        cmp_cnt++; if (valid_cycles !== vbase) begin err_cnt++; $display("FAIL short_valid: got %0d valid cycles want 0", valid_cycles - vbase); end
        clr_err();
        @(negedge clk_i);
        cmp_cnt++; if (frame_err_o !== 1'b0) begin err_cnt++; $display("FAIL short_clr: got %b want 0", frame_err_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] w [5];
        int base = got.size();
        for (int k = 0; k < 5; k++) w[k] = $urandom;
        rdy_mode = 0;
        cs_low();
        for (int k = 0; k < 4; k++) send_word(w[k]);
        for (int i = DW - 1; i >= 1; i--) spi_bit(w[4][i]);
        spi_sdo = w[4][0];
        repeat (H) @(posedge clk_i); #1 spi_sclk = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i); pulse_req = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i); pulse_req = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        cmp_cnt++; if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL fullpop_ovf: got %b want 0", overflow_o); end
        cmp_cnt++; if (got.size() - base !== 1) begin err_cnt++; $display("FAIL fullpop_popped: got %0d want 1", got.size() - base); end
        @(posedge clk_i); #1 spi_sclk = 1'b0;
        cs_high();
        rdy_mode = 1;
        repeat (20) @(posedge clk_i); #1;
        cmp_cnt++; if (got.size() - base !== 5) begin err_cnt++; $display("FAIL fullpop_count: got %0d want 5", got.size() - base); end
        for (int k = 0; k < 5 && base + k < got.size(); k++) begin
            cmp_cnt++; if (got[base+k] !== w[k]) begin err_cnt++; $display("FAIL fullpop_order%0d: got %h want %h", k, got[base+k], w[k]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] w = 32'h12345678;
        int base = got.size();
        rdy_mode = 1;
        cs_low();
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom_range(0, 1)));
        @(posedge clk_i); #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        cmp_cnt++; if ({busy_o, rx_valid_o} !== 2'b00) begin err_cnt++; $display("FAIL rstmid_out: got %b want 00", {busy_o, rx_valid_o}); end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (4) @(posedge clk_i); #1;
        for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(0, 1)));
        cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL rstmid_nostart: got %b want 0", busy_o); end
        cs_high();
        cs_low();
        send_word(w);
        cs_high();
        cmp_cnt++; if (got.size() - base !== 1) begin err_cnt++; $display("FAIL rstmid_count: got %0d want 1", got.size() - base); end
        if (got.size() > base) begin
            cmp_cnt++; if (got[base] !== w) begin err_cnt++; $display("FAIL rstmid_data: got %h want %h", got[base], w); end
        end
        cmp_cnt++; if (frame_err_o !== 1'b0) begin err_cnt++; $display("FAIL rstmid_ferr: got %b want 0", frame_err_o); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] w;
        int base = got.size();
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) begin
            int n = $urandom_range(1, 3);
            cs_low();
            for (int j = 0; j < n; j++) begin
                w = $urandom;
                exp_q.push_back(w);
                send_word(w);
            end
            cs_high();
        end
        rdy_mode = 1;
        repeat (20) @(posedge clk_i); #1;
        cmp_cnt++; if (got.size() - base !== exp_q.size()) begin err_cnt++; $display("FAIL b2b_count: got %0d want %0d", got.size() - base, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && base + k < got.size(); k++) begin
            cmp_cnt++; if (got[base+k] !== exp_q[k]) begin err_cnt++; $display("FAIL b2b_word%0d: got %h want %h", k, got[base+k], exp_q[k]); end
        end
        cmp_cnt++; if ({overflow_o, frame_err_o} !== 2'b00) begin err_cnt++; $display("FAIL b2b_flags: got %b want 00", {overflow_o, frame_err_o}); end
    endtask

    initial begin
        rst_ni    = 1'b0;
        spi_sclk  = 1'b0;
        spi_sdo   = 1'b0;
        spi_cs    = 1'b1;
        err_clr_i = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_short_frame();
        test_full_pop();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the received word width in bits (range 8..64).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the receive FIFO depth in words (power of two, 2..16).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port spi_sclk, input, 1 bit: SPI serial clock from spi_master, asynchronous to clk_i.
REQ-006 The block SHALL have port spi_sdo, input, 1 bit: serial data from spi_master, MSB first.
REQ-007 The block SHALL have port spi_cs, input, 1 bit: chip select, active-low.
REQ-008 The block SHALL have port rx_data_o, output, DATA_WIDTH bits: the word at the FIFO head.
REQ-009 The block SHALL have port rx_valid_o, output, 1 bit: FIFO not empty.
REQ-010 The block SHALL have port rx_ready_i, input, 1 bit: consumer accepts the head word.
REQ-011 The block SHALL have port err_clr_i, input, 1 bit: single-cycle clear of sticky errors.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: sticky flag, a word was dropped because the FIFO was full.
REQ-013 The block SHALL have port frame_err_o, output, 1 bit: sticky flag, spi_cs deasserted with a partial word.
REQ-014 The block SHALL have port busy_o, output, 1 bit: the FSM is in SHIFT.

Function
REQ-015 spi_sclk, spi_sdo and spi_cs SHALL each pass through a 2-flop synchronizer; reset values SHALL be sclk 0, sdo 0, cs 1.
REQ-016 A rising sclk event SHALL be the synchronized sclk at 1 while its previously registered value is 0; falling cs and rising cs events SHALL be detected the same way.
REQ-017 Operation is SPI mode 0 (CPOL=0, CPHA=0), and synchronized sdo SHALL be sampled on each rising sclk event.
REQ-018 Correct operation SHALL be guaranteed only when spi_sclk high and low phases are each at least 2 clk_i periods and spi_sdo is stable around the spi_sclk rising edge.
REQ-019 The FSM SHALL have two states, IDLE and SHIFT, and SHALL reset to IDLE.
REQ-020 IDLE: on a falling cs event, the FSM SHALL clear the bit counter and go to SHIFT; sclk events SHALL be ignored.
REQ-021 SHIFT: on each rising sclk event, the block SHALL shift sdo into the LSB of the shift register and increment the bit counter.
REQ-022 SHIFT: on the rising sclk event that carries bit DATA_WIDTH-1 (counter at DATA_WIDTH-1), the block SHALL push the completed word into the FIFO in that same cycle and wrap the counter to 0; the FSM SHALL stay in SHIFT, so multiple words per frame are allowed.
REQ-023 SHIFT: on a rising cs event, the FSM SHALL return to IDLE; if the counter is nonzero, the partial word SHALL be discarded and frame_err_o SHALL be set.
REQ-024 If the rising cs event and a rising sclk event occur in the same cycle, the sclk event SHALL be processed first, then the cs event.
REQ-025 Latency: rx_valid_o SHALL rise at the 3rd clk_i edge after the first clk_i edge that samples the last spi_sclk rising edge high, provided the FIFO was empty.
REQ-026 The FIFO SHALL be first-word-fall-through: rx_data_o is valid whenever rx_valid_o=1, and a pop occurs on rx_valid_o & rx_ready_i.
REQ-027 A push to a full FIFO SHALL drop the word and set overflow_o, unless a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-028 A push and a pop in the same cycle on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra pointer bit distinguishing full from empty.
REQ-030 err_clr_i SHALL clear overflow_o and frame_err_o; if an error event occurs in the same cycle, the flag SHALL remain set.
REQ-031 busy_o SHALL be 1 exactly while the FSM is in SHIFT.

Reset
REQ-032 While rst_ni=0, the block SHALL set the FSM to IDLE, the counter to 0, the shift register to 0, the FIFO to empty, and the synchronizers to the values in REQ-015.
REQ-033 While rst_ni=0, the outputs SHALL be rx_valid_o=0, rx_data_o=0, overflow_o=0, frame_err_o=0 and busy_o=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial word and all FIFO contents.
REQ-035 After reset release, the block SHALL not start a frame until a new falling cs event, even if spi_cs is already low.

Verification
REQ-036 Single word: send 0xA5A50F0F with rx_ready_i=1 -> one rx_valid_o pulse with rx_data_o=0xA5A50F0F, latency per REQ-025, no errors.
REQ-037 Burst overflow: send five words 1..5 in one frame with rx_ready_i=0 -> four words 1..4 are held and overflow_o=1; then rx_ready_i=1 drains 1,2,3,4 in order.
REQ-038 Short frame: send 7 bits then raise spi_cs -> frame_err_o=1 and rx_valid_o stays 0; err_clr_i pulse -> frame_err_o=0.
REQ-039 Full with simultaneous pop: FIFO full and rx_ready_i=1 in the push cycle -> the new word is stored, overflow_o stays 0, occupancy stays FIFO_DEPTH.
REQ-040 Reset mid-frame: assert rst_ni=0 after 16 bits, release it, then send 0x12345678 -> exactly one word, 0x12345678, is received.
